// File: rtl/edge_chk_pkg.sv
// Shared types and the edge-match helper for the edge implication checker.
package edge_chk_pkg;

  typedef enum logic [1:0] {
    ROSE   = 2'd0,
    FELL   = 2'd1,
    ANY    = 2'd2,
    STABLE = 2'd3
  } edge_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chk_state_e;

  // True when the transition prev -> cur satisfies the requested edge mode.
  function automatic logic edge_match(input edge_mode_e mode, input logic cur, input logic prev);
    logic m;
    m = 1'b0;
    case (mode)
      ROSE:    m = cur & ~prev;
      FELL:    m = ~cur & prev;
      ANY:     m = cur ^ prev;
      STABLE:  m = ~(cur ^ prev);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/edge_impl_ch.sv
// One checker channel: antecedent -> edge-on-monitor within a window,
// with registered verdict pulses, saturating counters and a sticky fail flag.
module edge_impl_ch
  import edge_chk_pkg::*;
#(
  parameter int WINDOW_MAX = 7,
  parameter int WIN_W      = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             ante_i,
  input  logic             mon_i,
  input  logic [1:0]       mode_i,
  input  logic [WIN_W-1:0] win_i,
  input  logic             clr_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             fail_seen_o
);

  localparam logic [WIN_W-1:0] WIN_LIM = WIN_W'(WINDOW_MAX);

  chk_state_e       r_state;
  edge_mode_e       r_mode;
  logic [WIN_W-1:0] r_cnt;
  logic             r_mon_prev;
  logic             r_pass;
  logic             r_fail;
  logic             r_fail_seen;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  chk_state_e       w_state_nxt;
  edge_mode_e       w_mode_nxt;
  logic [WIN_W-1:0] w_cnt_nxt;
  logic [WIN_W-1:0] w_win_clamp;
  logic             w_match_idle;
  logic             w_match_armed;
  logic             w_pass;
  logic             w_fail;

  assign w_win_clamp   = (win_i > WIN_LIM) ? WIN_LIM : win_i;
  // Idle evaluates the live mode; an armed check uses the mode captured at arming.
  assign w_match_idle  = edge_match(edge_mode_e'(mode_i), mon_i, r_mon_prev);
  assign w_match_armed = edge_match(r_mode, mon_i, r_mon_prev);

  // Next-state and verdict decision for the current edge.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_i && ante_i) begin
          if (w_match_idle) begin
            w_pass = 1'b1;
          end else if (w_win_clamp == '0) begin
            w_fail = 1'b1;
          end else begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = w_win_clamp;
            w_mode_nxt  = edge_mode_e'(mode_i);
          end
        end
      end
      ST_ARMED: begin
        // Disable aborts silently; antecedents are ignored while armed.
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_match_armed) begin
          w_pass      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == WIN_W'(1)) begin
          w_fail      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - WIN_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, captured mode/window counter, previous monitor sample and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= ROSE;
      r_cnt      <= '0;
      r_mon_prev <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mon_prev <= mon_i;
      r_pass     <= w_pass;
      r_fail     <= w_fail;
    end
  end

  // Saturating counters and sticky flag; clear wins over a same-edge verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
    end else if (clr_i) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
    end else begin
      if (w_pass && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (w_fail && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      if (w_fail) r_fail_seen <= 1'b1;
    end
  end

  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign pass_cnt_o  = r_pass_cnt;
  assign fail_cnt_o  = r_fail_cnt;
  assign fail_seen_o = r_fail_seen;

endmodule

// File: rtl/edge_impl_checker.sv
// Multi-channel edge implication checker: NUM_CH independent channels
// and a combined sticky "any channel failed" flag.
module edge_impl_checker #(
  parameter int NUM_CH     = 4,
  parameter int WINDOW_MAX = 7,
  parameter int CNT_W      = 8,
  localparam int WIN_W     = $clog2(WINDOW_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       ante_i,
  input  logic [NUM_CH-1:0]       mon_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [WIN_W*NUM_CH-1:0] win_i,
  input  logic                    clr_i,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [CNT_W*NUM_CH-1:0] pass_cnt_o,
  output logic [CNT_W*NUM_CH-1:0] fail_cnt_o,
  output logic                    fail_any_o
);

  logic [NUM_CH-1:0] w_fail_seen;

  // One checker instance per channel, sliced out of the packed buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_impl_ch #(
      .WINDOW_MAX (WINDOW_MAX),
      .WIN_W      (WIN_W),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en_i[g]),
      .ante_i      (ante_i[g]),
      .mon_i       (mon_i[g]),
      .mode_i      (mode_i[2*g +: 2]),
      .win_i       (win_i[WIN_W*g +: WIN_W]),
      .clr_i       (clr_i),
      .pass_o      (pass_o[g]),
      .fail_o      (fail_o[g]),
      .pass_cnt_o  (pass_cnt_o[CNT_W*g +: CNT_W]),
      .fail_cnt_o  (fail_cnt_o[CNT_W*g +: CNT_W]),
      .fail_seen_o (w_fail_seen[g])
    );
  end

  assign fail_any_o = |w_fail_seen;

endmodule

// File: tb/tb_edge_impl_checker.sv
// Directed, table-driven bench for edge_impl_checker.
module tb_edge_impl_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Main DUT: 4 channels, window 7, 8-bit counters.
  logic [3:0]  en, ante, mon;
  logic [7:0]  mode;
  logic [11:0] win;
  logic        clr;
  logic [3:0]  pass, fail;
  logic [31:0] pcnt, fcnt;
  logic        fany;

  // Second DUT: 1 channel, window limit 5 (3-bit window), 2-bit counters.
  logic       en2, ante2, mon2, clr2;
  logic [1:0] mode2;
  logic [2:0] win2;
  logic       pass2, fail2, fany2;
  logic [1:0] pcnt2, fcnt2;

  int tests = 0;
  int fails = 0;

  edge_impl_checker #(.NUM_CH(4), .WINDOW_MAX(7), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .ante_i(ante), .mon_i(mon),
    .mode_i(mode), .win_i(win), .clr_i(clr), .pass_o(pass), .fail_o(fail),
    .pass_cnt_o(pcnt), .fail_cnt_o(fcnt), .fail_any_o(fany)
  );

  edge_impl_checker #(.NUM_CH(1), .WINDOW_MAX(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_i(en2), .ante_i(ante2), .mon_i(mon2),
    .mode_i(mode2), .win_i(win2), .clr_i(clr2), .pass_o(pass2), .fail_o(fail2),
    .pass_cnt_o(pcnt2), .fail_cnt_o(fcnt2), .fail_any_o(fany2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, ante, mon;
    logic [1:0] mode;
    logic [2:0] win;
    logic       clr;
    logic       pass, fail;
    logic [7:0] pc, fc;
    logic       fa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int e, int a, int m, int md, int w, int c,
                              int p, int f, int pc, int fc, int fa);
    vec_t v;
    v.en = 1'(e); v.ante = 1'(a); v.mon = 1'(m); v.mode = 2'(md); v.win = 3'(w);
    v.clr = 1'(c); v.pass = 1'(p); v.fail = 1'(f); v.pc = 8'(pc); v.fc = 8'(fc);
    v.fa = 1'(fa);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic seen;

    en = '0; ante = '0; mon = '0; mode = '0; win = '0; clr = 1'b0;
    en2 = 1'b0; ante2 = 1'b0; mon2 = 1'b0; mode2 = '0; win2 = '0; clr2 = 1'b0;

    // ch0 stimulus: en ante mon mode win clr | pass fail pcnt fcnt fany
    tbl.push_back(mk(1,1,1,0,0,0, 1,0,1,0,0)); // ROSE from reset prev=0
    tbl.push_back(mk(1,1,1,0,0,0, 0,1,1,1,1)); // held high, win 0 -> fail
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,1,1,1)); // pulses last one cycle
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0)); // clear
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,3,0, 0,0,0,0,0)); // FELL win3 arm
    tbl.push_back(mk(1,0,1,0,0,0, 0,0,0,0,0)); // live mode changed, ignored
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,0,0)); // fall inside window -> pass
    tbl.push_back(mk(1,1,0,1,3,0, 0,0,1,0,0)); // FELL win3 arm, no fall
    tbl.push_back(mk(1,0,0,1,3,0, 0,0,1,0,0));
    tbl.push_back(mk(1,0,0,1,3,0, 0,0,1,0,0));
    tbl.push_back(mk(1,0,0,1,3,0, 0,1,1,1,1)); // window expiry -> fail
    tbl.push_back(mk(1,0,0,1,3,1, 0,0,0,0,0)); // clear
    tbl.push_back(mk(1,1,0,2,2,0, 0,0,0,0,0)); // ANY win2 arm
    tbl.push_back(mk(1,1,0,2,2,0, 0,0,0,0,0)); // re-ante ignored
    tbl.push_back(mk(1,1,0,2,2,0, 0,1,0,1,1)); // single fail
    tbl.push_back(mk(1,0,0,2,2,0, 0,0,0,1,1));
    tbl.push_back(mk(1,1,0,3,0,0, 1,0,1,1,1)); // STABLE same-cycle pass
    tbl.push_back(mk(1,1,1,3,2,0, 0,0,1,1,1)); // STABLE win2 arm
    tbl.push_back(mk(0,0,1,3,2,0, 0,0,1,1,1)); // disable aborts silently
    tbl.push_back(mk(1,0,1,3,2,0, 0,0,1,1,1)); // idle: stable edge not a pass

    // Reset state
    #2;
    chk("rst pass_o", 32'(pass), 32'h0);
    chk("rst fail_o", 32'(fail), 32'h0);
    chk("rst pass_cnt", pcnt, 32'h0);
    chk("rst fail_cnt", fcnt, 32'h0);
    chk("rst fail_any", 32'(fany), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-channel vectors
    for (int i = 0; i < tbl.size(); i++) begin
      en[0] = tbl[i].en; ante[0] = tbl[i].ante; mon[0] = tbl[i].mon;
      mode[1:0] = tbl[i].mode; win[2:0] = tbl[i].win; clr = tbl[i].clr;
      tick();
      chk($sformatf("v%0d pass", i), 32'(pass[0]), 32'(tbl[i].pass));
      chk($sformatf("v%0d fail", i), 32'(fail[0]), 32'(tbl[i].fail));
      chk($sformatf("v%0d pcnt", i), 32'(pcnt[7:0]), 32'(tbl[i].pc));
      chk($sformatf("v%0d fcnt", i), 32'(fcnt[7:0]), 32'(tbl[i].fc));
      chk($sformatf("v%0d fany", i), 32'(fany), 32'(tbl[i].fa));
      @(negedge clk);
    end
    en = '0; ante = '0; clr = 1'b0;

    // Counter saturation with 2-bit counters: five ANY passes
    en2 = 1'b1; ante2 = 1'b1; mode2 = 2'd2; win2 = 3'd0;
    for (int k = 0; k < 5; k++) begin
      mon2 = ~mon2;
      tick();
      @(negedge clk);
    end
    chk("sat pass_cnt", 32'(pcnt2), 32'd3);
    // Clear coincident with a pass
    clr2 = 1'b1; mon2 = ~mon2;
    tick();
    chk("clr pass_o", 32'(pass2), 32'd1);
    chk("clr pass_cnt", 32'(pcnt2), 32'd0);
    @(negedge clk);
    clr2 = 1'b0;
    // Window 7 clamped to 5: fail lands on the 5th edge after arming
    win2 = 3'd7;
    tick();
    @(negedge clk);
    ante2 = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (fail2) begin
        n = k;
        break;
      end
      @(negedge clk);
    end
    chk("clamp fail edge", 32'(n), 32'd5);
    chk("clamp fail_cnt", 32'(fcnt2), 32'd1);
    chk("clamp fail_any", 32'(fany2), 32'd1);
    @(negedge clk);
    en2 = 1'b0;

    // Reset mid-window on ch1 (ROSE, win 5)
    en = 4'b0010; ante = 4'b0010; mon = '0;
    mode = '0; win = '0; win[5:3] = 3'd5;
    tick();
    @(negedge clk);
    ante = '0;
    tick();
    @(negedge clk);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst pass_o", 32'(pass), 32'h0);
    chk("midrst fail_o", 32'(fail), 32'h0);
    chk("midrst pass_cnt", pcnt, 32'h0);
    chk("midrst fail_cnt", fcnt, 32'h0);
    chk("midrst fail_any", 32'(fany), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mon = 4'b0010; // a rise that would pass if the check were still armed
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      seen = seen | (|pass) | (|fail);
      @(negedge clk);
    end
    chk("midrst no pulse", 32'(seen), 32'h0);

    // Four channels concurrently
    rst_n = 1'b0;
    en = '0; ante = '0; mon = '0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    en = 4'b1111; ante = 4'b1111; mon = 4'b0001;
    mode = {2'd3, 2'd2, 2'd1, 2'd0};
    win = {3'd0, 3'd1, 3'd0, 3'd0};
    tick();
    chk("conc e1 pass", 32'(pass), 32'h9);
    chk("conc e1 fail", 32'(fail), 32'h2);
    @(negedge clk);
    ante = '0; mon = 4'b0101;
    mode[5:4] = 2'd3; // armed ch2 keeps its captured ANY
    tick();
    chk("conc e2 pass", 32'(pass), 32'h4);
    chk("conc e2 fail", 32'(fail), 32'h0);
    chk("conc pass_cnt", pcnt, 32'h01010001);
    chk("conc fail_cnt", fcnt, 32'h00000100);
    chk("conc fail_any", 32'(fany), 32'h1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/edge_impl_checker.md
EDGE_IMPL_CHECKER -- requirements
Module: edge_impl_checker

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent checker channels (1..32).
REQ-002 The block SHALL have parameter WINDOW_MAX, default 7, giving the largest allowed consequent window in cycles; WIN_W = $clog2(WINDOW_MAX+1).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel saturating counter.
REQ-004 clk  input  1  the single clock; all sampling is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  NUM_CH  per-channel enable.
REQ-007 ante_i  input  NUM_CH  per-channel antecedent.
REQ-008 mon_i  input  NUM_CH  per-channel monitored signal.
REQ-009 mode_i  input  2*NUM_CH  per-channel edge mode (edge_mode_e: ROSE=0, FELL=1, ANY=2, STABLE=3).
REQ-010 win_i  input  WIN_W*NUM_CH  per-channel window in cycles (0 = same-cycle, overlapping implication).
REQ-011 clr_i  input  1  synchronous clear of counters and sticky flag.
REQ-012 pass_o  output  NUM_CH  one-cycle pass pulse per channel.
REQ-013 fail_o  output  NUM_CH  one-cycle fail pulse per channel.
REQ-014 pass_cnt_o  output  CNT_W*NUM_CH  per-channel pass count.
REQ-015 fail_cnt_o  output  CNT_W*NUM_CH  per-channel fail count.
REQ-016 fail_any_o  output  1  sticky flag: any channel has failed since reset or clear.

Function
REQ-017 Each channel SHALL hold mon_prev, the value of mon_i sampled at the previous rising edge of clk; an edge match at edge k is evaluated on mon_i(k) vs mon_prev.
REQ-018 Edge match by mode: ROSE = 0->1; FELL = 1->0; ANY = any change; STABLE = no change.
REQ-019 Each channel SHALL be an FSM with states IDLE and ARMED, plus a down-counter of WIN_W bits.
REQ-020 In IDLE with en_i=1 and ante_i=1: on edge match, emit pass; else if win_i=0, emit fail; else go to ARMED with the counter loaded to win_i.
REQ-021 In ARMED: on edge match, emit pass and go to IDLE; else decrement the counter; on the edge where the counter goes from 1 to 0 with no match, emit fail and go to IDLE.
REQ-022 Antecedents arriving while in ARMED SHALL be ignored (non-overlapping re-arm).
REQ-023 Dropping en_i while in ARMED SHALL return the channel to IDLE next edge with no verdict.
REQ-024 mode_i and win_i SHALL be captured at arming; changes while in ARMED take effect only at the next arming.
REQ-025 pass_o and fail_o SHALL be registered at the deciding edge, high for exactly one cycle, and never high together.
REQ-026 Counters SHALL increment on each pulse and saturate at 2^CNT_W-1.
REQ-027 clr_i SHALL zero the counters and fail_any_o with priority over a same-edge increment; pulses still appear and FSMs are unaffected.
REQ-028 win_i values above WINDOW_MAX SHALL be clamped to WINDOW_MAX at load.

Reset
REQ-029 On rst_n=0 all FSMs SHALL go to IDLE, and mon_prev, counters, pass_o, fail_o and fail_any_o SHALL go to 0, asynchronously.
REQ-030 With mon_prev=0 after reset, mon_i=1 at the first edge SHALL count as a rise.
REQ-031 Reset asserted while in ARMED SHALL discard the pending check with no pulse.

Structure
REQ-032 The package edge_chk_pkg SHALL hold the edge_mode_e typedef and the state enum.
REQ-033 One sub-module, edge_impl_ch, SHALL implement a single channel (FSM, mon_prev, counters); the top level SHALL generate NUM_CH instances and OR the sticky flag.

Verification
REQ-034 ROSE, win=0, ch0: ante=1 with mon 0->1 at the same edge -> pass_o[0] pulses 1 cycle later and pass_cnt=1; ante=1 with mon held at 1 -> fail_o[0] pulses and fail_any_o=1.
REQ-035 FELL, win=3: ante at edge 10, mon falls at edge 12 -> pass at edge 12; with no fall -> fail at edge 13.
REQ-036 ANY, win=2: second ante at edge 11 while armed from edge 10, no mon change -> exactly one fail (at edge 12); counters show 0/1.
REQ-037 CNT_W=2: five passes -> pass_cnt=3 (saturated); clr_i coincident with a pass -> pass_o pulses and pass_cnt=0.
REQ-038 rst_n pulsed low mid-window on ch1 (win=5) -> no pulse, state IDLE, all outputs 0; NUM_CH=4 channels run concurrently with independent verdicts.
